// File: rtl/mul32fp_arbiter.sv
// mul32fp_arbiter: round-robin sharing of one multiplier32FP between NREQ requesters,
// with a watchdog that aborts an operation whose done never arrives.
module mul32fp_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_i,
   input  logic [32*NREQ-1:0]   a_i,
   input  logic [32*NREQ-1:0]   b_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      valid_o,
   output logic [31:0]          result_o,
   output logic [4:0]           flags_o,
   output logic                 busy_o,
   output logic                 mul_start_o,
   output logic [31:0]          mul_a_o,
   output logic [31:0]          mul_b_o,
   input  logic [31:0]          mul_product_i,
   input  logic                 mul_done_i,
   input  logic                 mul_nan_i,
   input  logic                 mul_infinit_i,
   input  logic                 mul_overflow_i,
   input  logic                 mul_underflow_i
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, WAIT_LOW} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, owner, sel;
   logic [PW:0]     idx;
   logic [9:0]      wd;
   logic [NREQ-1:0] owner_oh;
   logic            found, wd_exp;

   // first requester at or above ptr, wrapping
   always_comb begin
      sel = ptr;
      found = 1'b0;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!found && req_i[idx[PW-1:0]]) begin
            sel = idx[PW-1:0];
            found = 1'b1;
         end
      end
   end

   assign wd_exp = wd == 10'(TIMEOUT-1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = found ? ISSUE : IDLE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: state_nxt = (mul_done_i || wd_exp) ? RESP : WAIT_DONE;
         RESP:      state_nxt = WAIT_LOW;
         WAIT_LOW:  state_nxt = mul_done_i ? WAIT_LOW : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign owner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << owner;
   assign gnt_o       = (state == ISSUE) ? owner_oh : '0;
   assign valid_o     = (state == RESP) ? owner_oh : '0;
   assign mul_start_o = state == ISSUE;
   assign busy_o      = state != IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         wd       <= '0;
         mul_a_o  <= '0;
         mul_b_o  <= '0;
         result_o <= '0;
         flags_o  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            owner   <= sel;
            mul_a_o <= a_i[{sel, 5'd0} +: 32];
            mul_b_o <= b_i[{sel, 5'd0} +: 32];
         end
         if (state == ISSUE) wd <= '0;
         if (state == WAIT_DONE) begin
            wd <= wd + 10'd1;
            if (mul_done_i) begin
               result_o <= mul_product_i;
               flags_o  <= {1'b0, mul_underflow_i, mul_overflow_i, mul_infinit_i, mul_nan_i};
            end else if (wd_exp) begin
               result_o <= 32'h7FC00000;
               flags_o  <= 5'b10000;
            end
         end
         if (state == RESP) ptr <= (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);
      end
   end
endmodule

// File: doc/mul32fp_arbiter.md
# mul32fp_arbiter

Round-robin arbiter and sequencer that shares one `multiplier32FP` instance between `NREQ` requesters. It accepts operand pairs from the requesters and issues a single-cycle `start_i` pulse to the multiplier. It then waits on the multiplier's level-style `done_o`, captures the product and exception flags, and returns them to the owning requester with a one-cycle valid pulse. A watchdog terminates any operation whose `done_o` never arrives.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 64: cycles spent in WAIT_DONE before the operation is aborted; range 2..1023.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  NREQ  per-requester request level; held until matching `gnt_o`.
- `a_i`  in  32*NREQ  operand A, requester k in bits [32k+31:32k].
- `b_i`  in  32*NREQ  operand B, same packing as `a_i`.
- `gnt_o`  out  NREQ  one-hot grant pulse; operands were sampled on the edge that raised it.
- `valid_o`  out  NREQ  one-hot result pulse to the owning requester.
- `result_o`  out  32  captured product, held until the next capture.
- `flags_o`  out  5  {timeout, underflow, overflow, infinit, nan}, held like `result_o`.
- `busy_o`  out  1  high in every state except IDLE.
- `mul_start_o`  out  1  to `multiplier32FP.start_i`.
- `mul_a_o`  out  32  to `multiplier32FP.a_i`.
- `mul_b_o`  out  32  to `multiplier32FP.b_i`.
- `mul_product_i`  in  32  from `multiplier32FP.product_o`.
- `mul_done_i`  in  1  from `multiplier32FP.done_o`.
- `mul_nan_i`, `mul_infinit_i`, `mul_overflow_i`, `mul_underflow_i`  in  1 each  multiplier exception flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP, WAIT_LOW. All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- **IDLE, arbitration.** If any `req_i` is set, select the first set bit at or above `ptr`, wrapping modulo NREQ.
  - Latch `owner` and the selected `a`/`b` slices into `mul_a_o`/`mul_b_o`.
  - Move to ISSUE.
- **ISSUE**, exactly 1 cycle.
  - `mul_start_o` = 1 and `gnt_o[owner]` = 1.
  - Clear the watchdog counter `wd`.
  - Move to WAIT_DONE.
- **WAIT_DONE.** `wd` increments every cycle.
  - If `mul_done_i` = 1: capture `mul_product_i` into `result_o` and the four multiplier flags into `flags_o` with timeout = 0. Move to RESP.
  - Else if `wd` = TIMEOUT-1: set `result_o` = 32'h7FC00000 and `flags_o` = 5'b10000. Move to RESP.
  - Done takes priority if it coincides with the timeout cycle.
- **RESP**, exactly 1 cycle.
  - `valid_o[owner]` = 1.
  - `ptr` <= (owner+1) mod NREQ.
  - Move to WAIT_LOW.
- **WAIT_LOW.** Stay until `mul_done_i` = 0, then move to IDLE. If `mul_done_i` is already 0, this costs exactly 1 cycle.
- **Requests during an operation.** `req_i` changes outside IDLE are ignored. A requester whose request is pending stays pending and is not dropped.
- **Operand hold.** `mul_a_o`/`mul_b_o` hold their values from ISSUE through WAIT_LOW.
- **Same requester re-requesting.** It may assert again right after its `valid_o`. It is considered at the next IDLE with lowest priority.
- **Reset.** All outputs 0, `ptr` = 0, `owner` = 0, `wd` = 0, state IDLE.
  - Reset mid-operation discards the operation with no `valid_o`.
  - The multiplier shares `rst_n`.

## Timing
- Request sampled in IDLE at edge T:
  - `gnt_o` and `mul_start_o` are high in cycle T+1.
  - WAIT_DONE begins at T+2.
- Multiplier done seen at edge D: `valid_o` and the new `result_o` are visible in cycle D+1.
- **Throughput.** The next `mul_start_o` can occur no sooner than 3 cycles after `mul_done_i` falls: WAIT_LOW exit, IDLE, ISSUE.
- **Timeout.** With no done, `valid_o` rises exactly TIMEOUT+1 cycles after the `mul_start_o` cycle.
- `mul_start_o` is never high for more than 1 consecutive cycle and never high while `mul_done_i` = 1.
- `gnt_o`, `valid_o` and `mul_start_o` are each at most one-hot and at most 1 cycle wide.

## Test plan
- **Single request.** Requester 0 sends 3FC00000 × 40000000 (1.5×2.0).
  - Expect one `gnt_o[0]` pulse coincident with `mul_start_o`.
  - Expect `valid_o[0]` with `result_o` = 40400000 and `flags_o` = 0.
  - Expect `busy_o` to fall after `done` drops.
- **Round robin.** Both requesters hold `req_i` continuously, four operations total.
  - Grant order is 0,1,0,1.
  - Each `valid_o` goes to the granted requester with the correct product.
- **Exceptions.** 7F800000 × 00000000 → `result_o` NaN and `flags_o[0]` = 1. 7F7FFFFF × 7F7FFFFF → `flags_o[2]` (overflow) = 1.
- **Timeout.** Replace the multiplier with a stub whose `done` stays 0, TIMEOUT=8.
  - `valid_o` arrives 9 cycles after start.
  - `result_o` = 7FC00000 and `flags_o` = 10000.
  - The next request is served normally.
- **Reset mid-operation.** Assert `rst_n` = 0 during WAIT_DONE.
  - All outputs go to 0 immediately and no `valid_o` is issued.
  - After release, a fresh request completes correctly with `ptr` = 0.
- **Sticky done.** Stub holds `done` high for 5 cycles after completion. Expect no second `valid_o` and no `mul_start_o` until `done` is low.
